// File: rtl/alu_cmd_driver_if.sv
// Command and response handshake bundle between a command producer and alu_cmd_driver.
// The producer side uses the master modport; the driver uses the slave modport.
interface alu_cmd_driver_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [2:0]       rsp_op;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the combinational ALU: buffers commands in a FIFO, issues them
// one at a time, captures the result and returns it; an accumulator can stand in for operand a.
module alu_cmd_driver #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    alu_cmd_driver_if.slave            bus,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [2:0]                 alu_control,
    input  logic [WIDTH-1:0]           alu_result,
    output logic [WIDTH-1:0]           acc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [2:0] OP_MAX_LEGAL = 3'b100;

    logic [2:0]       op_mem     [DEPTH];
    logic [WIDTH-1:0] a_mem      [DEPTH];
    logic [WIDTH-1:0] b_mem      [DEPTH];
    logic             use_acc_mem[DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             load;

    logic [1:0]       state;
    logic [1:0]       state_nx;

    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic [2:0]       rsp_op_q;
    logic             rsp_err_q;
    logic             rsp_hs;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Full refuses a push even when a pop lands on the same edge.
    assign bus.cmd_ready = !full && !rst;
    assign push          = bus.cmd_valid && !full && !rst;

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_op     = rsp_op_q;
    assign bus.rsp_err    = rsp_err_q;

    assign rsp_hs = rsp_valid_q && bus.rsp_ready;
    assign busy   = (state != S_IDLE) || !empty;

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_nx = S_ISSUE;
                    load     = 1'b1;
                end
            end
            S_ISSUE: begin
                state_nx = S_RESP;
            end
            S_RESP: begin
                if (rsp_hs) begin
                    if (!empty) begin
                        state_nx = S_ISSUE;
                        load     = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]      <= bus.cmd_op;
            a_mem[wr_ptr]       <= bus.cmd_a;
            b_mem[wr_ptr]       <= bus.cmd_b;
            use_acc_mem[wr_ptr] <= bus.cmd_use_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, load})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_control  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_err_q    <= 1'b0;
            acc          <= '0;
        end else begin
            state <= state_nx;

            if (load) begin
                alu_a       <= use_acc_mem[rd_ptr] ? acc : a_mem[rd_ptr];
                alu_b       <= b_mem[rd_ptr];
                alu_control <= op_mem[rd_ptr];
            end

            // Illegal codes still produce a response, but never disturb the accumulator.
            if (state == S_ISSUE) begin
                rsp_valid_q  <= 1'b1;
                rsp_result_q <= alu_result;
                rsp_op_q     <= alu_control;
                rsp_err_q    <= (alu_control > OP_MAX_LEGAL);
                if (alu_control <= OP_MAX_LEGAL) begin
                    acc <= alu_result;
                end
            end else if (rsp_hs) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: table-driven single commands, hand-written
// multi-cycle sequences and a randomized run checked against an in-order reference model.
module tb_alu_cmd_driver;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int          NV    = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_cmd_driver_if #(.WIDTH(WIDTH)) bus ();

    alu_cmd_driver #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .acc         (acc),
        .count       (count),
        .busy        (busy)
    );

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        logic [15:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // Stand-in for the external combinational ALU.
    always_comb begin
        alu_result = alu_ref(alu_control, alu_a, alu_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] res;
        logic [2:0]  op;
        logic        err;
        logic [15:0] acc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_push;
    exp_t        e_pop;
    logic [15:0] model_acc = 16'h0000;
    logic [15:0] a_eff;
    int          cyc       = 0;
    int          rsp_n     = 0;
    int          rsp_cyc_q[$];
    int          max_count = 0;

    // Reference model: commands complete strictly in order, so each expected response
    // and accumulator value can be computed at acceptance time.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            model_acc = 16'h0000;
        end else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_n++;
                rsp_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e_pop = exp_q.pop_front();
                    check("model_result", 32'(bus.rsp_result), 32'(e_pop.res));
                    check("model_op", 32'(bus.rsp_op), 32'(e_pop.op));
                    check("model_err", 32'(bus.rsp_err), 32'(e_pop.err));
                    check("model_acc", 32'(acc), 32'(e_pop.acc));
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                a_eff        = bus.cmd_use_acc ? model_acc : bus.cmd_a;
                e_push.res   = alu_ref(bus.cmd_op, a_eff, bus.cmd_b);
                e_push.op    = bus.cmd_op;
                e_push.err   = (bus.cmd_op > 3'd4);
                if (!e_push.err) begin
                    model_acc = e_push.res;
                end
                e_push.acc = model_acc;
                exp_q.push_back(e_push);
            end
            if (int'(count) > max_count) begin
                max_count = int'(count);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic use_acc, output bit ok);
        bit took;
        @(posedge clk);
        #1;
        bus.cmd_op      = op;
        bus.cmd_a       = a;
        bus.cmd_b       = b;
        bus.cmd_use_acc = use_acc;
        bus.cmd_valid   = 1'b1;
        took = 1'b0;
        for (int i = 0; i < 40 && !took; i++) begin
            @(negedge clk);
            took = bus.cmd_ready;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        ok = took;
    endtask

    task automatic wait_rsp(input int budget, output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < budget) begin
            @(negedge clk);
            lat++;
            got = bus.rsp_valid;
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && !busy;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
        check({tag, "_rsp_op"}, 32'(bus.rsp_op), 32'd0);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check({tag, "_alu_control"}, 32'(alu_control), 32'd0);
        check({tag, "_acc"}, 32'(acc), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        use_acc;
        logic [15:0] res;
        logic        err;
        logic [15:0] acc;
    } vec_t;

    vec_t vt[NV];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok;
        bit          got;
        bit          took;
        bit          saw;
        int          lat;
        int          n_acc;
        int          sent;
        int          rsp0;
        logic [15:0] snap_res;
        logic [2:0]  snap_op;

        vt[0]  = '{3'd0, 16'h1234, 16'h0011, 1'b0, 16'h1245, 1'b0, 16'h1245};
        vt[1]  = '{3'd0, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 16'h0008};
        vt[2]  = '{3'd1, 16'hDEAD, 16'h000A, 1'b1, 16'hFFFE, 1'b0, 16'hFFFE};
        vt[3]  = '{3'd4, 16'hBEEF, 16'hFFFF, 1'b1, 16'h0001, 1'b0, 16'h0001};
        vt[4]  = '{3'd0, 16'h0040, 16'h0002, 1'b0, 16'h0042, 1'b0, 16'h0042};
        vt[5]  = '{3'd6, 16'h0007, 16'h0007, 1'b0, 16'h0000, 1'b1, 16'h0042};
        vt[6]  = '{3'd3, 16'h0000, 16'h0100, 1'b1, 16'h0142, 1'b0, 16'h0142};
        vt[7]  = '{3'd2, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 1'b0, 16'h00F0};
        vt[8]  = '{3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[9]  = '{3'd7, 16'h1111, 16'h0001, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vt[10] = '{3'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF};

        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 3'd0;
        bus.cmd_a       = 16'h0000;
        bus.cmd_b       = 16'h0000;
        bus.cmd_use_acc = 1'b0;
        bus.rsp_ready   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("cmd_ready_in_rst", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            send(vt[i].op, vt[i].a, vt[i].b, vt[i].use_acc, ok);
            check("vec_accept", 32'(ok), 32'd1);
            wait_rsp(20, lat, got);
            check("vec_rsp_seen", 32'(got), 32'd1);
            if (got) begin
                check("vec_latency", 32'(lat), 32'd3);
                check("vec_result", 32'(bus.rsp_result), 32'(vt[i].res));
                check("vec_err", 32'(bus.rsp_err), 32'(vt[i].err));
                check("vec_op", 32'(bus.rsp_op), 32'(vt[i].op));
                check("vec_acc", 32'(acc), 32'(vt[i].acc));
            end
        end
        wait_drain(20, ok);
        check("vec_drain", 32'(ok), 32'd1);

        // Chain: three back-to-back commands, accumulator carried between them.
        rsp0 = rsp_n;
        send(3'd0, 16'h0005, 16'h0003, 1'b0, ok);
        check("chain_accept0", 32'(ok), 32'd1);
        send(3'd1, 16'h0000, 16'h000A, 1'b1, ok);
        check("chain_accept1", 32'(ok), 32'd1);
        send(3'd4, 16'h0000, 16'hFFFF, 1'b1, ok);
        check("chain_accept2", 32'(ok), 32'd1);
        wait_drain(40, ok);
        check("chain_drain", 32'(ok), 32'd1);
        check("chain_rsp_count", 32'(rsp_n - rsp0), 32'd3);
        check("chain_acc", 32'(acc), 32'h0001);

        // Backpressure: six offers with rsp_ready low, only 1+DEPTH fit.
        bus.rsp_ready = 1'b0;
        n_acc = 0;
        @(posedge clk);
        #1;
        bus.cmd_op = 3'd0; bus.cmd_a = 16'h0100; bus.cmd_b = 16'h0000; bus.cmd_use_acc = 1'b0;
        bus.cmd_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            took = bus.cmd_valid && bus.cmd_ready;
            @(posedge clk);
            #1;
            if (took) begin
                n_acc++;
                if (n_acc < 6) begin
                    bus.cmd_a = 16'h0100 + 16'(n_acc);
                    bus.cmd_b = 16'(n_acc);
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        check("bp_accepted", 32'(n_acc), 32'd5);
        check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("bp_count", 32'(count), 32'(DEPTH));
        check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_first_result", 32'(bus.rsp_result), 32'h0100);
        snap_res = bus.rsp_result;
        snap_op  = bus.rsp_op;
        repeat (3) @(negedge clk);
        check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_hold_result", 32'(bus.rsp_result), 32'(snap_res));
        check("bp_hold_op", 32'(bus.rsp_op), 32'(snap_op));
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        rsp_cyc_q.delete();
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 30 && rsp_cyc_q.size() < 5; c++) begin
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("bp_rsp_count", 32'(rsp_cyc_q.size()), 32'd5);
        if (rsp_cyc_q.size() == 5) begin
            for (int k = 1; k < 5; k++) begin
                check("bp_spacing", 32'(rsp_cyc_q[k] - rsp_cyc_q[k-1]), 32'd2);
            end
        end
        check("bp_busy_end", 32'(busy), 32'd0);
        check("bp_count_end", 32'(count), 32'd0);

        // Wrap-around: 11 random commands with random response stalls.
        max_count = 0;
        rsp0 = rsp_n;
        sent = 0;
        took = 1'b0;
        for (int c = 0; c < 600 && (sent < 11 || exp_q.size() != 0); c++) begin
            @(posedge clk);
            #1;
            if (took) begin
                bus.cmd_valid = 1'b0;
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if (!bus.cmd_valid && sent < 11 && $urandom_range(0, 1) == 1) begin
                bus.cmd_op      = 3'($urandom_range(0, 7));
                bus.cmd_a       = 16'($urandom);
                bus.cmd_b       = 16'($urandom);
                bus.cmd_use_acc = 1'($urandom_range(0, 1));
                bus.cmd_valid   = 1'b1;
            end
            @(negedge clk);
            took = bus.cmd_valid && bus.cmd_ready;
            if (took) begin
                sent++;
            end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_drain(40, ok);
        check("wrap_sent", 32'(sent), 32'd11);
        check("wrap_rsp_count", 32'(rsp_n - rsp0), 32'd11);
        check("wrap_drain", 32'(ok), 32'd1);
        check("wrap_count_le_depth", 32'(max_count <= int'(DEPTH)), 32'd1);

        // Reset while a response is pending and two commands are queued.
        bus.rsp_ready = 1'b0;
        send(3'd0, 16'h1000, 16'h0001, 1'b0, ok);
        send(3'd0, 16'h2000, 16'h0002, 1'b0, ok);
        send(3'd0, 16'h3000, 16'h0003, 1'b0, ok);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = bus.rsp_valid && (count == CW'(2));
        end
        check("rst_setup", 32'(got), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        bus.rsp_ready = 1'b1;
        rsp0 = rsp_n;
        saw  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid || busy) begin
                saw = 1'b1;
            end
        end
        check("midrst_no_rsp", 32'(saw), 32'd0);
        check("midrst_rsp_n", 32'(rsp_n - rsp0), 32'd0);
        send(3'd0, 16'hAAAA, 16'h0007, 1'b1, ok);
        check("midrst_accept", 32'(ok), 32'd1);
        wait_rsp(20, lat, got);
        check("midrst_rsp_seen", 32'(got), 32'd1);
        check("midrst_latency", 32'(lat), 32'd3);
        check("midrst_result", 32'(bus.rsp_result), 32'h0007);
        wait_drain(20, ok);
        check("midrst_drain", 32'(ok), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Command-side initiator for the 16-bit combinational ALU. It accepts operation commands through a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time to the ALU's `a`/`b`/`control` inputs, captures the ALU `result`, and returns it through a valid/ready response port. An optional accumulator lets each command take the previous result as operand `a`, so ALU ops can be chained without a round trip.

## Interface
- `DEPTH`, 4: command FIFO depth in entries; must be a power of 2 and ≥ 2.
- `WIDTH`, 16: operand/result width; must match the ALU.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals `!full && !rst`.
- `cmd_op`  in  3  ALU control code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR; 101–111 illegal.
- `cmd_a`  in  WIDTH  operand a; ignored when `cmd_use_acc` = 1.
- `cmd_b`  in  WIDTH  operand b.
- `cmd_use_acc`  in  1  replace `a` with the accumulator value at issue time.
- `alu_a`  out  WIDTH  registered, to ALU `a`.
- `alu_b`  out  WIDTH  registered, to ALU `b`.
- `alu_control`  out  3  registered, to ALU `control`.
- `alu_result`  in  WIDTH  from ALU `result` (combinational).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  WIDTH  captured ALU result.
- `rsp_op`  out  3  op code of the response.
- `rsp_err`  out  1  op code was illegal.
- `acc`  out  WIDTH  current accumulator value.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `busy`  out  1  high when the FSM is not in IDLE or `count` ≠ 0.

## Operation
- **FIFO.** Entry = {op, a, b, use_acc}.
  - Push when `cmd_valid && cmd_ready`.
  - Pop on the FSM load event.
  - Pointers wrap modulo DEPTH.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - A push into an empty FIFO becomes visible to the FSM in the next cycle (no bypass).
- **FSM states.** IDLE, ISSUE, RESP.
  - IDLE → ISSUE when `count` ≠ 0; load event (see below).
  - ISSUE → RESP always, after one cycle.
    - Capture on that edge: `rsp_result` ← `alu_result`, `rsp_op` ← `alu_control`, `rsp_err` ← (`alu_control` > 3'b100).
    - Set `rsp_valid`.
  - RESP: hold all `rsp_*` stable until `rsp_valid && rsp_ready`.
    - On the handshake, if `count` ≠ 0: → ISSUE with a load event.
    - On the handshake, otherwise: → IDLE and clear `rsp_valid`.
- **Load event.** Pop the head entry.
  - `alu_a` ← `use_acc ? acc : a`.
  - `alu_b` ← `b`.
  - `alu_control` ← `op`.
  - `alu_*` hold their last values at all other times.
- **Accumulator.**
  - `acc` ← `alu_result` at the ISSUE→RESP edge, for legal ops only.
  - Illegal ops leave `acc` unchanged. They are still issued to the ALU, whose result is 0, so the response is `rsp_result`=0, `rsp_err`=1.
- **Arithmetic.** Performed entirely by the ALU and modulo 2^WIDTH. This block does no arithmetic and does not report carry or overflow.

## Timing
- **Reset values:**
  - `cmd_ready`=0 while `rst` is high; 1 in the first cycle after reset.
  - `alu_a`=0, `alu_b`=0, `alu_control`=0.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_op`=0, `rsp_err`=0.
  - `acc`=0, `count`=0, `busy`=0.
  - FSM in IDLE.
- **Latency.** Command accepted at edge N with the FSM idle and the FIFO empty → load at edge N+1 → `rsp_valid` high after edge N+2.
- **Throughput.** With `rsp_ready` held high and the FIFO non-empty: one response per 2 cycles (ISSUE, RESP alternating).
- **Chaining.** A `use_acc` command issued directly after a response sees the `acc` value written by that response.
- **Simultaneous events.**
  - Push and pop in the same cycle: `count` unchanged.
  - Push while in RESP: allowed.
- **Reset mid-operation.**
  - FIFO contents, any in-flight op and any pending response are discarded.
  - All outputs return to their reset values at the next edge.
  - No response is produced for discarded commands.

## Test plan
- **Single ADD.** Push op 000, a=0x1234, b=0x0011, `rst` idle.
  - Expect `rsp_valid` 3 cycles after acceptance.
  - Expect `rsp_result`=0x1245, `rsp_err`=0, `acc`=0x1245.
- **Chain.** Push ADD a=5 b=3, then SUB use_acc b=10, then XOR use_acc b=0xFFFF.
  - Expect results 0x0008, 0xFFFE, 0x0001; `acc`=0x0001 at the end.
- **Illegal op.** Push op 110 a=7 b=7 with `acc`=0x0042.
  - Expect `rsp_result`=0, `rsp_err`=1, `rsp_op`=110; `acc` stays 0x0042.
- **Backpressure and full.** Hold `rsp_ready`=0 and push 6 commands.
  - Expect exactly 1+DEPTH=5 accepted, `cmd_ready`=0 afterwards, and `rsp_*` stable.
  - Then release `rsp_ready`: expect 5 responses in order, one every 2 cycles, and `busy`=0 at the end.
- **Wrap-around.** Push and drain 11 commands through a DEPTH=4 FIFO with random `rsp_ready` stalls.
  - Expect in-order results matching a reference model.
  - Expect `count` never to exceed 4.
- **Reset mid-op.** Assert `rst` for 1 cycle while in RESP with 2 commands queued.
  - Expect all outputs at reset values and no further `rsp_valid` until a new push.
